// File: rtl/systolic_result_collector.sv
// systolic_result_collector: double-buffered capture of systolic array results, one frame of N samples.
// Rev 1.0
`default_nettype none

module systolic_result_collector #(
  parameter int N       = 8,
  parameter int LATENCY = 2
) (
  input  logic                 clk30x,
  input  logic                 rst,
  input  logic                 donext,
  input  logic [15:0]          yout,
  input  logic                 rd_en,
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic [31:0]          rd_data,
  output logic                 rd_valid,
  output logic                 frame_ready,
  input  logic                 frame_ack,
  output logic                 overrun
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] WR_INIT  = AW'((N - LATENCY) % N);
  localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);

  typedef enum logic {FILL = 1'b0, SWAP = 1'b1} state_t;

  logic [31:0]   bank0 [N];
  logic [31:0]   bank1 [N];
  logic          donext_q;
  logic          fill_sel;
  logic          ovr_pend;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] cnt;
  state_t        state;

  logic strobe;
  logic comp;
  logic wsel;

  assign strobe = donext & ~donext_q;
  assign comp   = strobe && (state == FILL) && (cnt == CNT_LAST);
  // During the exchange cycle the incoming sample belongs to the bank about to become the fill bank.
  assign wsel   = (state == SWAP) ? ~fill_sel : fill_sel;

  always_ff @(posedge clk30x) begin
    if (strobe) begin
      if (wsel) bank1[wr_ptr] <= {{16{yout[15]}}, yout};
      else      bank0[wr_ptr] <= {{16{yout[15]}}, yout};
    end
  end

  always_ff @(posedge clk30x or posedge rst) begin
    if (rst) begin
      donext_q    <= 1'b0;
      wr_ptr      <= WR_INIT;
      cnt         <= '0;
      state       <= FILL;
      fill_sel    <= 1'b0;
      ovr_pend    <= 1'b0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      donext_q <= donext;
      if (strobe) begin
        wr_ptr <= wr_ptr + 1'b1;
        cnt    <= cnt + 1'b1;
      end

      case (state)
        FILL: begin
          if (comp) begin
            // An ack coinciding with completion releases the old frame, so no overrun.
            state    <= SWAP;
            ovr_pend <= frame_ready & ~frame_ack;
          end else if (frame_ack) begin
            frame_ready <= 1'b0;
          end
        end
        SWAP: begin
          fill_sel    <= ~fill_sel;
          frame_ready <= 1'b1;
          if (ovr_pend && !frame_ack) overrun <= 1'b1;
          state       <= FILL;
        end
        default: state <= FILL;
      endcase

      if (rd_en && frame_ready) begin
        rd_valid <= 1'b1;
        rd_data  <= fill_sel ? bank0[rd_addr] : bank1[rd_addr];
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_result_collector.sv
// tb_systolic_result_collector: randomized and directed checks against a frame-level reference model.
// Rev 1.0
`default_nettype none

module tb_systolic_result_collector;

  localparam int N  = 8;
  localparam int L  = 2;
  localparam int AW = $clog2(N);

  logic          clk30x = 1'b0;
  logic          rst;
  logic          donext;
  logic [15:0]   yout;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          frame_ready;
  logic          frame_ack;
  logic          overrun;

  systolic_result_collector #(.N(N), .LATENCY(L)) dut (
    .clk30x      (clk30x),
    .rst         (rst),
    .donext      (donext),
    .yout        (yout),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .overrun     (overrun)
  );

  always #5 clk30x = ~clk30x;

  // Reference model: samples of the frame in progress, and the last completed frame by address.
  logic [31:0] cur [$];
  logic [31:0] rframe [N];
  bit          m_ready;
  bit          m_ovr;
  logic [31:0] m_last;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk30x);
    #1;
  endtask

  task automatic model_reset();
    cur.delete();
    m_ready = 0;
    m_ovr   = 0;
    m_last  = '0;
  endtask

  task automatic model_capture(input logic [15:0] v, input bit ack);
    cur.push_back({{16{v[15]}}, v});
    if (cur.size() == N) begin
      for (int k = 0; k < N; k++) rframe[(k + N - L) % N] = cur[k];
      if (m_ready && !ack) m_ovr = 1;
      m_ready = 1;
      cur.delete();
    end else if (ack) begin
      m_ready = 0;
    end
  endtask

  task automatic check_status();
    chk("frame_ready", {31'b0, frame_ready}, {31'b0, m_ready});
    chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
  endtask

  task automatic do_reset();
    donext = 0; rd_en = 0; frame_ack = 0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    check_status();
  endtask

  task automatic strobe(input logic [15:0] v, input int hold, input bit ack);
    yout = v; donext = 1'b1; frame_ack = ack;
    tick();
    frame_ack = 1'b0;
    yout = 16'($urandom);
    for (int i = 1; i < hold; i++) tick();
    donext = 1'b0;
    tick();
    model_capture(v, ack);
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    m_ready = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    logic [31:0] exp_d;
    bit          exp_v;
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    exp_v = m_ready;
    if (m_ready) m_last = rframe[a];
    exp_d = m_last;
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_v});
    chk("rd_data", rd_data, exp_d);
    tick();
    chk("rd_valid_drop", {31'b0, rd_valid}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; donext = 0; yout = '0; rd_en = 0; rd_addr = '0; frame_ack = 0;
    model_reset();
    repeat (2) @(posedge clk30x);
    #1;
    check_status();
    do_reset();

    // Ramp frame: result k = k+1.
    for (int k = 0; k < N; k++) strobe(16'(k + 1), 1, 1'b0);
    check_status();
    rd(3'd6); chk("ramp_a6", rd_data, 32'd1);
    rd(3'd7); chk("ramp_a7", rd_data, 32'd2);
    rd(3'd0); chk("ramp_a0", rd_data, 32'd3);
    rd(3'd5); chk("ramp_a5", rd_data, 32'd8);

    // Sign extension, plus a long-held strobe inside the frame.
    ack();
    check_status();
    rd(3'd1);
    strobe(16'h8001, 1, 1'b0);
    strobe(16'h7FFF, 1, 1'b0);
    strobe(16'h1234, 5, 1'b0);
    for (int k = 3; k < N - 1; k++) strobe(16'($urandom), 1, 1'b0);
    check_status();
    strobe(16'hBEEF, 1, 1'b0);
    check_status();
    rd(3'd6); chk("sext_neg", rd_data, 32'hFFFF8001);
    rd(3'd7); chk("sext_pos", rd_data, 32'h00007FFF);
    rd(3'd0); chk("held_once", rd_data, 32'h00001234);

    // Two frames without release.
    ack();
    for (int k = 0; k < 2 * N; k++) strobe(16'($urandom), 1, 1'b0);
    check_status();
    for (int a = 0; a < N; a++) rd(AW'(a));

    // Ack coinciding with completion of the next frame.
    do_reset();
    for (int k = 0; k < N; k++) strobe(16'($urandom), 1, 1'b0);
    for (int k = 0; k < N - 1; k++) strobe(16'($urandom), 1, 1'b0);
    strobe(16'h4321, 1, 1'b1);
    check_status();
    rd(3'd5); chk("ack_same_new", rd_data, 32'h00004321);

    // Reset mid-frame, then a full frame.
    for (int k = 0; k < 3; k++) strobe(16'($urandom), 1, 1'b0);
    do_reset();
    for (int k = 0; k < N; k++) strobe(16'(k + 16'h100), 1, 1'b0);
    check_status();
    for (int a = 0; a < N; a++) rd(AW'(a));

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5)      strobe(16'($urandom), $urandom_range(1, 3), ($urandom_range(0, 7) == 0));
      else if (r <= 7) rd(AW'($urandom_range(0, N - 1)));
      else if (r == 8) ack();
      else             tick();
      check_status();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/systolic_result_collector.md
SYSTOLIC_RESULT_COLLECTOR -- requirements
Module: systolic_result_collector

Interface
REQ-001 SHALL have parameter N, default 8, meaning samples per frame (power of two, 2..64).
REQ-002 SHALL have parameter LATENCY, default 2, meaning array pipeline offset in strobes, 0..N-1.
REQ-003 SHALL have port clk30x  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port donext  input  1  sample strobe from the feeder; may stay high for more than one cycle.
REQ-006 SHALL have port yout  input  16  signed two's-complement array output.
REQ-007 SHALL have port rd_en  input  1  read request for the completed frame.
REQ-008 SHALL have port rd_addr  input  log2(N)  read index within the completed frame.
REQ-009 SHALL have port rd_data  output  32  sign-extended result.
REQ-010 SHALL have port rd_valid  output  1  rd_data valid.
REQ-011 SHALL have port frame_ready  output  1  a completed frame is available for reading.
REQ-012 SHALL have port frame_ack  input  1  reader releases the completed frame.
REQ-013 SHALL have port overrun  output  1  sticky flag: a frame completed while the previous frame was unreleased.

Function
REQ-014 SHALL detect a strobe as donext high in the current cycle and low in the previous registered cycle; a level held high SHALL count as one strobe.
REQ-015 SHALL, on each strobe cycle, capture yout from that same cycle as {16{yout[15]}, yout} into the fill bank at address wr_ptr.
REQ-016 SHALL implement the fill bank and the read bank as two N x 32 banks (double buffer).
REQ-017 SHALL reset wr_ptr to (N-LATENCY) mod N and increment it modulo N on each strobe; result k therefore lands at address (k+N-LATENCY) mod N.
REQ-018 SHALL keep a strobe counter 0..N-1; on the strobe bringing it to N, it SHALL wrap to 0, swap banks in the following cycle and set frame_ready.
REQ-019 SHALL make rd_data equal to read-bank[rd_addr] one cycle after an rd_en cycle, with rd_valid high for exactly that cycle; rd_en with frame_ready low SHALL give rd_valid 0 and rd_data unchanged.
REQ-020 SHALL clear frame_ready in the cycle after a frame_ack cycle; frame_ack with frame_ready low SHALL be ignored.
REQ-021 SHALL, when a frame completes while frame_ready is high, still swap banks, keep frame_ready high and set overrun; overrun SHALL clear only on rst.
REQ-022 SHALL, when frame_ack and frame completion occur in the same cycle, treat the ack as applying to the old frame: banks swap, frame_ready stays high and overrun is not set.
REQ-023 SHALL ensure a strobe and a swap in the same cycle write the new fill bank without losing a sample.
REQ-024 SHALL implement a two-state controller: FILL (counting strobes) and SWAP (one-cycle bank exchange, strobe accepted), SWAP always returning to FILL.

Reset
REQ-025 SHALL, on rst high, asynchronously force rd_data=0, rd_valid=0, frame_ready=0, overrun=0, wr_ptr=(N-LATENCY) mod N, counter=0, state FILL and the registered donext=0.
REQ-026 SHALL, when rst asserts mid-frame, discard the partial frame; bank contents need not be cleared.
REQ-027 SHALL accept a strobe on the first rising edge after rst deasserts.

Verification
REQ-028 Bench SHALL cover: N=8, LATENCY=2, yout=k+1 on strobes k=0..7 -> frame_ready=1; rd_addr 6 gives 1, addr 7 gives 2, addr 0 gives 3, addr 5 gives 8.
REQ-029 Bench SHALL cover: yout=16'h8001 captured -> rd_data=32'hFFFF8001; yout=16'h7FFF -> 32'h00007FFF.
REQ-030 Bench SHALL cover: donext held high for 5 cycles -> exactly one capture, and the counter advances by 1.
REQ-031 Bench SHALL cover: 16 strobes with no frame_ack -> overrun=1, frame_ready=1, and the read bank holds the second frame.
REQ-032 Bench SHALL cover: frame_ack in the same cycle as the 8th strobe of the next frame -> overrun=0, frame_ready=1, and the new frame is readable.
REQ-033 Bench SHALL cover: rst pulse after 3 strobes, then 8 strobes -> one frame_ready, with data aligned per REQ-017.
